// File: rtl/div_arbiter.sv
// div_arbiter: shares one iterative divider between two requesters.
// Requests are arbitrated in IDLE. The winner's operands are latched and
// held steady while the divider runs. The result is registered and
// announced with a one-cycle done_o pulse. A flush from the owner aborts
// the divide and waits two cycles so the divider is free again.
// Build option: define DIVARB_ROUND_ROBIN_EN for round-robin arbitration.
// The default is fixed priority, where requester 0 always wins.
module div_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_i,
   input  logic [1:0]  signed_i,
   input  logic [31:0] op1_0_i,
   input  logic [31:0] op2_0_i,
   input  logic [31:0] op1_1_i,
   input  logic [31:0] op2_1_i,
   input  logic [1:0]  annul_i,
   output logic [1:0]  gnt_o,
   output logic [1:0]  done_o,
   output logic [63:0] result_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_opdata1_o,
   output logic [31:0] div_opdata2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_gnt;
   logic        r_owner;
   logic        r_abort_cnt;
   logic        r_signed;
   logic [31:0] r_op1;
   logic [31:0] r_op2;
   logic [63:0] r_result;

   logic [1:0]  w_valid;
   logic        w_win;
   logic        w_load;
   logic        w_capture;
   logic        w_start;
   logic        w_annul;
   logic        w_done;
   logic        w_owner_annul;

   // A request that is being flushed in the same cycle is not a candidate.
   assign w_valid       = req_i & ~annul_i;
   assign w_owner_annul = annul_i[r_owner];

`ifdef DIVARB_ROUND_ROBIN_EN
   logic r_ptr;

   // The pointed requester wins ties; otherwise the only valid one wins.
   assign w_win = w_valid[r_ptr] ? r_ptr : ~r_ptr;

   // After the owner finishes or aborts, hand priority to the other side.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_ptr <= 1'b0;
      else if ((r_state == DONE) || ((r_state == ABORT) && (w_next == IDLE)))
         r_ptr <= ~r_owner;
   end
`else
   // Fixed priority: requester 1 only wins when it is the sole candidate.
   assign w_win = (w_valid == 2'b10);
`endif

   // Next-state and divider control decode.
   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_capture = 1'b0;
      w_start   = 1'b0;
      w_annul   = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_valid) begin
               w_load = 1'b1;
               w_next = BUSY;
            end
         end
         BUSY: begin
            // A flush beats a result that arrives in the same cycle.
            if (w_owner_annul) begin
               w_annul = 1'b1;
               w_next  = ABORT;
            end else begin
               w_start = 1'b1;
               if (div_ready_i) begin
                  w_capture = 1'b1;
                  w_next    = DONE;
               end
            end
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         ABORT: begin
            if (r_abort_cnt)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Grant, owner, operand latch and result capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gnt    <= 2'b00;
         r_owner  <= 1'b0;
         r_signed <= 1'b0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_result <= '0;
      end else begin
         if (w_load) begin
            r_gnt    <= w_win ? 2'b10 : 2'b01;
            r_owner  <= w_win;
            r_signed <= signed_i[w_win];
            r_op1    <= w_win ? op1_1_i : op1_0_i;
            r_op2    <= w_win ? op2_1_i : op2_0_i;
         end else if ((w_next == IDLE) && (r_state != IDLE)) begin
            r_gnt <= 2'b00;
         end
         if (w_capture)
            r_result <= div_result_i;
      end
   end

   // Two-cycle abort counter. It is always zero when ABORT is entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_abort_cnt <= 1'b0;
      else if (r_state == ABORT)
         r_abort_cnt <= ~r_abort_cnt;
      else
         r_abort_cnt <= 1'b0;
   end

   assign gnt_o         = r_gnt;
   assign done_o        = w_done ? r_gnt : 2'b00;
   assign result_o      = r_result;
   assign div_start_o   = w_start;
   assign div_annul_o   = w_annul;
   assign div_signed_o  = r_signed;
   assign div_opdata1_o = r_op1;
   assign div_opdata2_o = r_op2;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter. It includes a simple behavioural divider
// with a fixed latency. The divider returns {rem, quot}, or zero for a zero
// divisor.
module tb_div_arbiter;

   localparam int DIV_LAT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_i = '0;
   logic [1:0]  signed_i = '0;
   logic [31:0] op1_0_i = '0, op2_0_i = '0, op1_1_i = '0, op2_1_i = '0;
   logic [1:0]  annul_i = '0;
   logic [1:0]  gnt_o, done_o;
   logic [63:0] result_o;
   logic        div_start_o, div_annul_o, div_signed_o;
   logic [31:0] div_opdata1_o, div_opdata2_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   int checks = 0;
   int failures = 0;

   div_arbiter dut (
      .clk(clk), .rst(rst), .req_i(req_i), .signed_i(signed_i),
      .op1_0_i(op1_0_i), .op2_0_i(op2_0_i), .op1_1_i(op1_1_i), .op2_1_i(op2_1_i),
      .annul_i(annul_i), .gnt_o(gnt_o), .done_o(done_o), .result_o(result_o),
      .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
      .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
      .div_result_i(div_result_i), .div_ready_i(div_ready_i)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] divf(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Divider model: ready rises DIV_LAT cycles after start is first seen.
   int m_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt        <= 0;
         div_ready_i  <= 1'b0;
         div_result_i <= '0;
      end else if (div_annul_o || !div_start_o) begin
         m_cnt       <= 0;
         div_ready_i <= 1'b0;
      end else if (div_ready_i) begin
         div_ready_i <= 1'b0;
      end else if (m_cnt == DIV_LAT - 1) begin
         div_ready_i  <= 1'b1;
         div_result_i <= divf(div_signed_o, div_opdata1_o, div_opdata2_o);
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done_o != 2'b00) begin
            cyc = i;
            return;
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, gnt_o, 2'b00);
      chk({tag, "_done"}, done_o, 2'b00);
      chk({tag, "_result"}, result_o, 64'd0);
      chk({tag, "_start"}, div_start_o, 1'b0);
      chk({tag, "_annul"}, div_annul_o, 1'b0);
      chk({tag, "_signed"}, div_signed_o, 1'b0);
      chk({tag, "_op1"}, div_opdata1_o, 32'd0);
      chk({tag, "_op2"}, div_opdata2_o, 32'd0);
   endtask

   localparam logic [63:0] RES_A = {32'd2, 32'd14};
   localparam logic [63:0] RES_B = {32'hFFFFFFFF, 32'hFFFFFFFD};

   initial begin
      int cyc;
      int spurious;
      logic [1:0] exp_g [3];
`ifdef DIVARB_ROUND_ROBIN_EN
      exp_g = '{2'b01, 2'b10, 2'b01};
`else
      exp_g = '{2'b01, 2'b01, 2'b01};
`endif

      // Reset state
      repeat (2) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b1;
      @(negedge clk);
      chk("rst_idle_start", div_start_o, 1'b0);

      // Unsigned 100/7 from requester 0
      op1_0_i = 32'd100; op2_0_i = 32'd7; signed_i = 2'b00; req_i = 2'b01;
      @(negedge clk);
      chk("t1_gnt", gnt_o, 2'b01);
      chk("t1_start", div_start_o, 1'b1);
      chk("t1_op1", div_opdata1_o, 32'd100);
      chk("t1_op2", div_opdata2_o, 32'd7);
      chk("t1_signed", div_signed_o, 1'b0);
      wait_done(cyc);
      chk("t1_latency", cyc + 1, DIV_LAT + 2);
      chk("t1_done", done_o, 2'b01);
      chk("t1_gnt_done", gnt_o, 2'b01);
      chk("t1_result", result_o, RES_A);
      chk("t1_start_done", div_start_o, 1'b0);
      req_i = 2'b00;
      @(negedge clk);
      chk("t1_done_once", done_o, 2'b00);
      chk("t1_gnt_idle", gnt_o, 2'b00);

      // Signed -7/2 from requester 1
      op1_1_i = 32'hFFFFFFF9; op2_1_i = 32'd2; signed_i = 2'b10; req_i = 2'b10;
      @(negedge clk);
      chk("t2_gnt", gnt_o, 2'b10);
      chk("t2_signed", div_signed_o, 1'b1);
      chk("t2_op1", div_opdata1_o, 32'hFFFFFFF9);
      wait_done(cyc);
      chk("t2_done", done_o, 2'b10);
      chk("t2_result", result_o, RES_B);
      req_i = 2'b00;
      @(negedge clk);

      // Both requesters held for three back-to-back divides
      op1_0_i = 32'd100; op2_0_i = 32'd7;
      req_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("t3_gnt%0d", k), gnt_o, exp_g[k]);
         chk($sformatf("t3_start%0d", k), div_start_o, 1'b1);
         wait_done(cyc);
         chk($sformatf("t3_done%0d", k), done_o, exp_g[k]);
         chk($sformatf("t3_res%0d", k), result_o, (exp_g[k] == 2'b01) ? RES_A : RES_B);
         @(negedge clk);
         chk($sformatf("t3_gap%0d", k), div_start_o, 1'b0);
         if (k == 2) req_i = 2'b00;
      end

      // Abort of requester 0 with requester 1 pending
      req_i = 2'b01;
      @(negedge clk);
      chk("t4_gnt", gnt_o, 2'b01);
      req_i = 2'b11; annul_i = 2'b10;
      #1;
      chk("t4_nonowner_annul", div_annul_o, 1'b0);
      chk("t4_nonowner_start", div_start_o, 1'b1);
      @(negedge clk);
      annul_i = 2'b00;
      repeat (8) @(negedge clk);
      annul_i = 2'b01;
      #1;
      chk("t4_annul", div_annul_o, 1'b1);
      chk("t4_annul_start", div_start_o, 1'b0);
      @(negedge clk);
      annul_i = 2'b00; req_i = 2'b10;
      chk("t4_ab1_start", div_start_o, 1'b0);
      chk("t4_ab1_annul", div_annul_o, 1'b0);
      chk("t4_ab1_done", done_o, 2'b00);
      chk("t4_ab_result", result_o, (exp_g[2] == 2'b01) ? RES_A : RES_B);
      @(negedge clk);
      chk("t4_ab2_start", div_start_o, 1'b0);
      chk("t4_ab2_done", done_o, 2'b00);
      @(negedge clk);
      chk("t4_idle_start", div_start_o, 1'b0);
      chk("t4_idle_gnt", gnt_o, 2'b00);
      @(negedge clk);
      chk("t4_gnt1", gnt_o, 2'b10);
      chk("t4_start1", div_start_o, 1'b1);
      wait_done(cyc);
      chk("t4_done1", done_o, 2'b10);
      chk("t4_res1", result_o, RES_B);
      req_i = 2'b00;
      @(negedge clk);

      // Reset in the middle of a divide
      req_i = 2'b01;
      repeat (4) @(negedge clk);
      chk("t5_busy", div_start_o, 1'b1);
      rst = 1'b0;
      #1;
      chk_reset_vals("t5_midrst");
      req_i = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      spurious = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_o != 2'b00 || div_start_o) spurious++;
      end
      chk("t5_quiet", spurious, 0);

      // Normal divide after reset, then divide by zero
      req_i = 2'b01;
      wait_done(cyc);
      chk("t6_done", done_o, 2'b01);
      chk("t6_result", result_o, RES_A);
      req_i = 2'b00;
      @(negedge clk);
      op2_0_i = 32'd0; req_i = 2'b01;
      wait_done(cyc);
      chk("t7_dz_done", done_o, 2'b01);
      chk("t7_dz_result", result_o, 64'd0);
      req_i = 2'b00;
      @(negedge clk);
      chk("t7_dz_once", done_o, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
